// File: rtl/st_rr_arb_stage.sv
// Round-robin arbiter feeding one registered valid/ready stage shared by NREQ requesters.
// Optional packet lock is enabled by defining ST_RR_ARB_LOCK_EN.
module st_rr_arb_stage #(
    parameter int NREQ = 4,
    parameter int DW = 32,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   i_vld,
    output logic [NREQ-1:0]   i_rdy,
    input  logic [NREQ-1:0]   i_last,
    input  logic [NREQ*DW-1:0] data_i,
    output logic              o_vld,
    input  logic              o_rdy,
    output logic [DW-1:0]     data_o,
    output logic [IDW-1:0]    o_id,
    output logic              o_last
);

    // Handshake: a beat moves when valid and ready are both high at a rising edge;
    // valid never waits on ready, and ready is offered to at most one requester per cycle.
    logic           stage_free;
    logic           gnt_vld;
    logic [IDW-1:0] gnt_id;
    logic [IDW-1:0] ptr;
    logic           push;
    logic [DW-1:0]  gnt_data;

`ifdef ST_RR_ARB_LOCK_EN
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_LOCK = 1'b1;

    logic [0:0]     lock_state;
    logic [IDW-1:0] lid;
    logic           lock;
    logic           gnt_last;
    logic           o_last_q;

    assign lock = (lock_state == ST_LOCK);
`endif

    assign stage_free = ~o_vld | o_rdy;

    always_comb begin
        int idx;
        gnt_vld = 1'b0;
        gnt_id  = ptr;
        idx     = 0;
`ifdef ST_RR_ARB_LOCK_EN
        if (lock) begin
            // Mid-packet only the owner may proceed; a gap from it stalls everyone.
            gnt_vld = i_vld[lid];
            gnt_id  = lid;
        end else begin
`else
        begin
`endif
            for (int off = 0; off < NREQ; off++) begin
                idx = int'(ptr) + off;
                if (idx >= NREQ) idx = idx - NREQ;
                if (!gnt_vld && i_vld[idx]) begin
                    gnt_vld = 1'b1;
                    gnt_id  = IDW'(idx);
                end
            end
        end
    end

    // Ready is withheld during reset so no beat is handed over and then dropped.
    always_comb begin
        i_rdy = '0;
        if (gnt_vld && stage_free && rst) i_rdy[gnt_id] = 1'b1;
    end

    assign push     = gnt_vld & stage_free;
    assign gnt_data = data_i[int'(gnt_id) * DW +: DW];

    always_ff @(posedge clk) begin
        if (!rst) begin
            o_vld  <= 1'b0;
            data_o <= '0;
            o_id   <= '0;
            ptr    <= '0;
        end else if (push) begin
            o_vld  <= 1'b1;
            data_o <= gnt_data;
            o_id   <= gnt_id;
            // While locked gnt_id is lid, so ptr settles on lid+1 and stays there.
            ptr    <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
        end else if (o_rdy) begin
            o_vld  <= 1'b0;
        end
    end

`ifdef ST_RR_ARB_LOCK_EN
    assign gnt_last = i_last[gnt_id];

    always_ff @(posedge clk) begin
        if (!rst) begin
            lock_state <= ST_IDLE;
            lid        <= '0;
            o_last_q   <= 1'b0;
        end else if (push) begin
            o_last_q <= gnt_last;
            if (gnt_last) begin
                lock_state <= ST_IDLE;
            end else begin
                lock_state <= ST_LOCK;
                lid        <= gnt_id;
            end
        end
    end

    assign o_last = o_last_q;
`else
    logic unused_last;

    assign unused_last = ^i_last;
    assign o_last      = 1'b1;
`endif

endmodule

// File: tb/tb_st_rr_arb_stage.sv
// Directed bench for st_rr_arb_stage: expected beats are queued on the input side and
// compared as the output stage hands them downstream.
module tb_st_rr_arb_stage;
    localparam int NREQ = 4;
    localparam int DW   = 32;
    localparam int IDW  = 2;
    localparam int W    = IDW + 1 + DW;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   i_vld;
    logic [NREQ-1:0]   i_rdy;
    logic [NREQ-1:0]   i_last;
    logic [NREQ*DW-1:0] data_i;
    logic              o_vld;
    logic              o_rdy;
    logic [DW-1:0]     data_o;
    logic [IDW-1:0]    o_id;
    logic              o_last;

    int checks = 0;
    int fails  = 0;
    int pushed = 0;
    int popped = 0;
    logic [W-1:0]  exp_q[$];
    logic [DW-1:0] held;

    st_rr_arb_stage #(.NREQ(NREQ), .DW(DW)) dut (
        .clk    (clk),
        .rst    (rst),
        .i_vld  (i_vld),
        .i_rdy  (i_rdy),
        .i_last (i_last),
        .data_i (data_i),
        .o_vld  (o_vld),
        .o_rdy  (o_rdy),
        .data_o (data_o),
        .o_id   (o_id),
        .o_last (o_last)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_last(input logic l);
`ifdef ST_RR_ARB_LOCK_EN
        return l;
`else
        return 1'b1;
`endif
    endfunction

    // Drive one cycle; exp_g is the requester that must be accepted this cycle, -1 for none.
    task automatic step(input logic [NREQ-1:0] vld, input logic [NREQ-1:0] last,
                        input logic rdy, input int exp_g);
        logic [NREQ-1:0] exp_rdy;
        logic [W-1:0]    beat;
        i_vld  = vld;
        i_last = last;
        o_rdy  = rdy;
        for (int k = 0; k < NREQ; k++) data_i[k*DW +: DW] = $urandom;
        #1;
        exp_rdy = '0;
        if (exp_g >= 0) exp_rdy[exp_g] = 1'b1;
        chk("i_rdy", 64'(i_rdy), 64'(exp_rdy));
        if (exp_g >= 0) begin
            held = data_i[exp_g*DW +: DW];
            exp_q.push_back({IDW'(exp_g), exp_last(last[exp_g]), held});
            pushed++;
        end
        if (o_vld && o_rdy) begin
            if (exp_q.size() == 0) begin
                chk("spurious_beat", 64'(o_vld), 64'd0);
            end else begin
                beat = exp_q.pop_front();
                popped++;
                chk("o_id", 64'(o_id), 64'(beat[W-1 -: IDW]));
                chk("o_last", 64'(o_last), 64'(beat[DW]));
                chk("data_o", 64'(data_o), 64'(beat[DW-1:0]));
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [NREQ-1:0] all_last;
        all_last = '1;

        // Reset with every requester asking
        rst    = 1'b0;
        i_vld  = '1;
        i_last = '1;
        o_rdy  = 1'b1;
        data_i = '0;
        for (int n = 0; n < 3; n++) begin
            #1;
            chk("rst_i_rdy", 64'(i_rdy), 64'd0);
            @(posedge clk);
            #1;
            chk("rst_o_vld", 64'(o_vld), 64'd0);
        end
        chk("rst_data_o", 64'(data_o), 64'd0);
        chk("rst_o_id", 64'(o_id), 64'd0);
`ifdef ST_RR_ARB_LOCK_EN
        chk("rst_o_last", 64'(o_last), 64'd0);
`else
        chk("rst_o_last", 64'(o_last), 64'd1);
`endif
        rst = 1'b1;

        // Full rotation, one beat per cycle
        for (int n = 0; n < 8; n++) step(4'b1111, all_last, 1'b1, n % NREQ);

        // Backpressure on a held req2 beat
        step(4'b0100, all_last, 1'b1, 2);
        for (int n = 0; n < 2; n++) begin
            step(4'b0100, all_last, 1'b0, -1);
            chk("stall_o_vld", 64'(o_vld), 64'd1);
            chk("stall_o_id", 64'(o_id), 64'd2);
            chk("stall_data_o", 64'(data_o), 64'(held));
        end
        step(4'b0100, all_last, 1'b1, 2);

        // Wrap from ptr=3 to req1, then skip from ptr=2 to req3
        step(4'b0010, all_last, 1'b1, 1);
        step(4'b1001, all_last, 1'b1, 3);

        // Park ptr on req1
        step(4'b0001, all_last, 1'b1, 0);

`ifdef ST_RR_ARB_LOCK_EN
        // req1 three-beat packet with a gap; others must wait
        step(4'b0111, 4'b1101, 1'b1, 1);
        step(4'b0111, 4'b1101, 1'b1, 1);
        step(4'b0101, 4'b1101, 1'b1, -1);
        step(4'b0111, 4'b1111, 1'b1, 1);
        step(4'b0101, 4'b1111, 1'b1, 2);
`else
        // Same stimulus without lock interleaves freely
        step(4'b0111, 4'b1101, 1'b1, 1);
        step(4'b0111, 4'b1101, 1'b1, 2);
        step(4'b0111, 4'b1111, 1'b1, 0);
        step(4'b0111, 4'b1111, 1'b1, 1);
`endif

        // Drain
        for (int n = 0; n < 4 && exp_q.size() > 0; n++) step('0, all_last, 1'b1, -1);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        chk("beat_count", 64'(popped), 64'(pushed));
        chk("drain_o_vld", 64'(o_vld), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
